// File: rtl/pl_writeback_stage.sv
// ---------------------------------------------------------------------------
// pl_writeback_stage
//   MEM->WB pipeline stage. Registers the writeback result chosen from NSRC
//   non-load sources, or the sign/zero-extended load data taken from a
//   variable-latency data-memory response. Holds off the MEM stage while a
//   load is outstanding, and supports flush, including discarding a load
//   response that is already in flight.
//
// Handshake: an instruction is taken when m_valid & m_ready & ~flush.
//   m_ready is high only in IDLE. wb_valid is a one-cycle pulse. wb_rd,
//   wb_data and wb_misalign hold their last value while wb_valid is low.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   m_valid/m_ready   MEM-stage handshake
//   m_src, m_sel      packed result sources and non-load select
//   m_rd, m_regwrite  destination register and its write enable
//   m_is_load, m_funct3, m_addr_lo   load control
//   flush             kill the accepting instruction and any pending load
//   dm_rsp_valid, dm_rdata           data-memory response (one-cycle pulse)
//   wb_valid, wb_we, wb_rd, wb_data, wb_misalign   register-file writeback
//   stall_cycles      (WB_STALLCNT_EN only) cycles spent with m_ready low
//
// Optional feature macro: WB_STALLCNT_EN adds the stall_cycles counter.
// ---------------------------------------------------------------------------
module pl_writeback_stage #(
    parameter int W    = 32,
    parameter int NSRC = 4,
    parameter int RW   = 5,
    localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1,
    localparam int AW   = $clog2(W / 8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [NSRC*W-1:0] m_src,
    input  logic [SELW-1:0]   m_sel,
    input  logic [RW-1:0]     m_rd,
    input  logic              m_regwrite,
    input  logic              m_is_load,
    input  logic [2:0]        m_funct3,
    input  logic [AW-1:0]     m_addr_lo,
    input  logic              flush,
    input  logic              dm_rsp_valid,
    input  logic [W-1:0]      dm_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [RW-1:0]     wb_rd,
    output logic [W-1:0]      wb_data,
    output logic              wb_misalign
`ifdef WB_STALLCNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_wb_valid;
    logic              r_wb_we;
    logic [RW-1:0]     r_wb_rd;
    logic [W-1:0]      r_wb_data;
    logic              r_wb_misalign;

    // Pending-load context, kept apart from the wb_* registers so those hold.
    logic [RW-1:0]     r_ld_rd;
    logic              r_ld_regwrite;
    logic [2:0]        r_ld_funct3;
    logic [AW-1:0]     r_ld_addr_lo;

    logic              w_accept;
    logic [W-1:0]      w_src_sel;
    logic [2:0]        w_ext_f3;
    logic [AW-1:0]     w_ext_lo;
    logic [W-1:0]      w_shifted;
    logic [2*W-1:0]    w_sx_b;
    logic [2*W-1:0]    w_sx_h;
    logic [2*W-1:0]    w_sx_w;
    logic [2*W-1:0]    w_zx_w;
    logic [W-1:0]      w_ext_data;
    logic              w_ext_mis;

    assign m_ready  = (r_state == S_IDLE);
    assign w_accept = m_valid & m_ready & ~flush;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        w_src_sel = m_src[W-1:0];
        for (int i = 0; i < NSRC; i++) begin
            if (int'(m_sel) == i) w_src_sel = m_src[i*W +: W];
        end
    end

    // In IDLE the load is extended straight from the MEM inputs (same-cycle
    // response); otherwise from the captured pending-load context.
    assign w_ext_f3  = (r_state == S_IDLE) ? m_funct3  : r_ld_funct3;
    assign w_ext_lo  = (r_state == S_IDLE) ? m_addr_lo : r_ld_addr_lo;
    assign w_shifted = dm_rdata >> {w_ext_lo, 3'b000};

    // Double-width temporaries give clean sign extension for any legal W.
    assign w_sx_b = {{(2*W-8){w_shifted[7]}},   w_shifted[7:0]};
    assign w_sx_h = {{(2*W-16){w_shifted[15]}}, w_shifted[15:0]};
    assign w_sx_w = {{(2*W-32){w_shifted[31]}}, w_shifted[31:0]};
    assign w_zx_w = {{(2*W-32){1'b0}},          w_shifted[31:0]};

    always_comb begin
        w_ext_data = w_shifted;
        w_ext_mis  = 1'b0;
        case (w_ext_f3)
            3'b000: w_ext_data = w_sx_b[W-1:0];
            3'b100: w_ext_data = {{(W-8){1'b0}}, w_shifted[7:0]};
            3'b001: begin
                w_ext_data = w_sx_h[W-1:0];
                w_ext_mis  = w_ext_lo[0];
            end
            3'b101: begin
                w_ext_data = {{(W-16){1'b0}}, w_shifted[15:0]};
                w_ext_mis  = w_ext_lo[0];
            end
            3'b010: begin
                w_ext_data = w_sx_w[W-1:0];
                w_ext_mis  = (w_ext_lo[1:0] != 2'b00);
            end
            3'b110: begin
                // LWU exists only at W=64; at W=32 this is a plain full word.
                if (W == 64) begin
                    w_ext_data = w_zx_w[W-1:0];
                    w_ext_mis  = (w_ext_lo[1:0] != 2'b00);
                end else begin
                    w_ext_data = w_shifted;
                    w_ext_mis  = (w_ext_lo != '0);
                end
            end
            default: begin
                // LD and the unused encodings: full-width access.
                w_ext_data = w_shifted;
                w_ext_mis  = (w_ext_lo != '0);
            end
        endcase
        if (w_ext_mis) w_ext_data = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_wb_valid    <= 1'b0;
            r_wb_we       <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_wb_misalign <= 1'b0;
            r_ld_rd       <= '0;
            r_ld_regwrite <= 1'b0;
            r_ld_funct3   <= 3'b000;
            r_ld_addr_lo  <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!m_is_load) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_we       <= m_regwrite & (m_rd != '0);
                            r_wb_rd       <= m_rd;
                            r_wb_data     <= w_src_sel;
                            r_wb_misalign <= 1'b0;
                        end else if (dm_rsp_valid) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_we       <= m_regwrite & (m_rd != '0) & ~w_ext_mis;
                            r_wb_rd       <= m_rd;
                            r_wb_data     <= w_ext_data;
                            r_wb_misalign <= w_ext_mis;
                        end else begin
                            r_ld_rd       <= m_rd;
                            r_ld_regwrite <= m_regwrite;
                            r_ld_funct3   <= m_funct3;
                            r_ld_addr_lo  <= m_addr_lo;
                            r_state       <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dm_rsp_valid) begin
                        // A flush arriving with the response discards it.
                        if (!flush) begin
                            r_wb_valid    <= 1'b1;
                            r_wb_we       <= r_ld_regwrite & (r_ld_rd != '0) & ~w_ext_mis;
                            r_wb_rd       <= r_ld_rd;
                            r_wb_data     <= w_ext_data;
                            r_wb_misalign <= w_ext_mis;
                        end
                        r_state <= S_IDLE;
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Swallow the in-flight response of the killed load.
                    if (dm_rsp_valid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef WB_STALLCNT_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_stall_cycles <= 32'd0;
        else if (r_state != S_IDLE) r_stall_cycles <= r_stall_cycles + 32'd1;
    end
    assign stall_cycles = r_stall_cycles;
`endif

    assign wb_valid    = r_wb_valid;
    assign wb_we       = r_wb_we;
    assign wb_rd       = r_wb_rd;
    assign wb_data     = r_wb_data;
    assign wb_misalign = r_wb_misalign;

endmodule

// File: doc/pl_writeback_stage.md
Name: pl_writeback_stage

Overview:
Parametrised MEM→WB pipeline stage for the pipelined RV core.
- Registers the writeback result, selected from NSRC sources.
- Extracts and sign/zero-extends load data from a variable-latency data-memory response.
- Stalls the upstream stage while a load is outstanding.
- Supports flush, including discarding a load response that is already in flight.

Parameters:
W, 32, datapath width; legal values 32 or 64.
NSRC, 4, number of non-load result sources (ALU, PC+4, PC+imm, …).
RW, 5, register address width.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
m_valid  in  1  MEM-stage instruction valid.
m_ready  out  1  stage can accept; combinational, high only in IDLE.
m_src  in  NSRC*W  packed result sources; source i at bits [i*W +: W].
m_sel  in  $clog2(NSRC)  source select for non-loads.
m_rd  in  RW  destination register.
m_regwrite  in  1  instruction writes rd.
m_is_load  in  1  result comes from data memory.
m_funct3  in  3  load type.
m_addr_lo  in  $clog2(W/8)  low byte-address bits of the load.
flush  in  1  kill the instruction being accepted and any outstanding load.
dm_rsp_valid  in  1  data-memory read data valid; single-cycle pulse.
dm_rdata  in  W  raw aligned memory word.
wb_valid  out  1  one-cycle pulse: writeback result present.
wb_we  out  1  register-file write enable.
wb_rd  out  RW  register-file address.
wb_data  out  W  register-file write data.
wb_misalign  out  1  load was misaligned; qualified by wb_valid.

Behaviour:
- **Reset (async, rst=1):** state IDLE; wb_valid=0, wb_we=0, wb_rd=0, wb_data=0, wb_misalign=0. m_ready=1 after reset.
- **wb_valid:** defaults to 0 every cycle. wb_we = wb_valid & captured regwrite & (rd≠0). wb_rd, wb_data and wb_misalign hold their last values when wb_valid=0.
- **IDLE, accept = m_valid & m_ready & ~flush:**
  - Non-load: wb_data ← m_src[m_sel]. Latency 1: wb_valid high the next cycle. Stay in IDLE.
  - m_sel ≥ NSRC: selects source 0.
  - Load with dm_rsp_valid in the same cycle: extended data registered, wb_valid next cycle, stay in IDLE.
  - Load without dm_rsp_valid: capture rd, regwrite, funct3, addr_lo; go to WAIT_LOAD.
- **WAIT_LOAD:**
  - m_ready=0.
  - On dm_rsp_valid & ~flush: register extended data, wb_valid next cycle, go to IDLE.
  - On flush without dm_rsp_valid: go to DRAIN.
  - On flush with dm_rsp_valid in the same cycle: discard the response, go to IDLE, no writeback.
- **DRAIN:**
  - m_ready=0, no writeback.
  - On dm_rsp_valid: discard, go to IDLE.
  - flush in DRAIN: no effect.
- **flush in IDLE:** suppresses acceptance; no writeback.
- **Load extension** (lane = addr_lo, byte granular):
  - 000 LB and 100 LBU: byte, sign- or zero-extended.
  - 001 LH and 101 LHU: half, sign- or zero-extended.
  - 010 LW: word, sign-extended to W.
  - W=64 only: 110 LWU, word zero-extended; 011 LD, full word.
  - Other funct3 values: treated as LW/LD of width W.
- **Misalignment:**
  - Half with addr_lo[0]=1, word with addr_lo[1:0]≠0, or double with addr_lo≠0: wb_misalign=1, wb_data=0, wb_we=0.
- **Reset mid-operation:** rst in WAIT_LOAD or DRAIN returns to IDLE. Any later dm_rsp_valid in IDLE without an accepted load is ignored.

Optional Feature:
- **WB_STALLCNT_EN defined:**
  - Adds output stall_cycles [31:0]: count of cycles spent in WAIT_LOAD or DRAIN.
  - Reset to 0; wraps at 2^32−1 → 0; counts in the same cycle as m_ready=0.
- **Undefined:** port and counter absent; all other behaviour identical.

Test Plan:
- m_sel=2, m_src[2]=0x0000_1234, rd=5, regwrite=1 → next cycle wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x0000_1234; m_ready stays 1.
- LB, addr_lo=3, dm_rdata=0x80FF_0000 with dm_rsp_valid in the same cycle → wb_data=0xFFFF_FF80 one cycle later; LBU → 0x0000_0080.
- LH, addr_lo=0, response 3 cycles later with dm_rdata=0x0000_8001:
  - m_ready=0 for 3 cycles, no wb_valid during the wait.
  - wb_data=0xFFFF_8001 one cycle after dm_rsp_valid.
  - (WB_STALLCNT_EN) stall_cycles=3.
- Load enters WAIT_LOAD, flush next cycle, dm_rsp_valid two cycles later → no wb_valid ever; m_ready returns 1 the cycle after the response.
- LW with addr_lo=2 → wb_valid=1, wb_misalign=1, wb_we=0, wb_data=0.
- rd=0 ALU op with regwrite=1 → wb_valid=1, wb_we=0. Separately: assert rst during WAIT_LOAD → outputs reset immediately and state is IDLE.
